countdown_mmss: RTL and testbench

//  Loadable mm:ss BCD countdown timer. It counts down through a borrow chain of
//  mod-10/mod-6 digits, the down-counting counterpart of our mod-N up-counter

---
 rtl/countdown_mmss.sv | 138 +++++++++++++
 tb/tb_countdown_mmss.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_mmss.sv
// Loadable mm:ss BCD countdown timer with a load/start/pause control FSM.
// The count decrements through a mod-10/mod-6 borrow chain on each en tick while running.
module countdown_mmss #(
    parameter int unsigned MIN_TENS_MAX = 5,
    parameter int unsigned AUTO_RELOAD  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic [1:0]  state,
    output logic        running,
    output logic        done,
    output logic        sec_bo
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    logic [15:0] count_q, count_n;
    logic [15:0] reload_q, reload_n;
    logic [1:0]  state_q, state_n;
    logic        running_q, done_q, done_n, sec_bo_q, sec_bo_n;

    logic [15:0] dec_val;
    logic [15:0] load_clamped;
    logic        bo0, bo1, bo2;
    logic [3:0]  so_d, st_d, mo_d, mt_d;

    // Out-of-range digits saturate to the largest legal value for their position.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        mt = (v[15:12] > MT_MAX) ? MT_MAX : v[15:12];
        mo = (v[11:8]  > 4'd9)   ? 4'd9   : v[11:8];
        st = (v[7:4]   > 4'd5)   ? 4'd5   : v[7:4];
        so = (v[3:0]   > 4'd9)   ? 4'd9   : v[3:0];
        return {mt, mo, st, so};
    endfunction

    assign load_clamped = clamp_bcd(load_val);

    // Borrow chain: each digit wraps to its max and borrows only when the lower digit borrows.
    always_comb begin
        bo0  = (count_q[3:0] == 4'd0);
        so_d = bo0 ? 4'd9 : count_q[3:0] - 4'd1;
        bo1  = 1'b0;
        st_d = count_q[7:4];
        if (bo0) begin
            bo1  = (count_q[7:4] == 4'd0);
            st_d = bo1 ? 4'd5 : count_q[7:4] - 4'd1;
        end
        bo2  = 1'b0;
        mo_d = count_q[11:8];
        if (bo1) begin
            bo2  = (count_q[11:8] == 4'd0);
            mo_d = bo2 ? 4'd9 : count_q[11:8] - 4'd1;
        end
        mt_d = bo2 ? count_q[15:12] - 4'd1 : count_q[15:12];
        dec_val = {mt_d, mo_d, st_d, so_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= 16'h0000;
            reload_q  <= 16'h0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            sec_bo_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            reload_q  <= reload_n;
            running_q <= (state_n == ST_RUN);
            done_q    <= done_n;
            sec_bo_q  <= sec_bo_n;
        end
    end

    // Next-state and next-count; load outside RUN takes priority over start.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        reload_n = reload_q;
        done_n   = 1'b0;
        sec_bo_n = 1'b0;
        if (load && (state_q != ST_RUN)) begin
            count_n  = load_clamped;
            reload_n = load_clamped;
            state_n  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (count_q != 16'h0000)) state_n = ST_RUN;
                end
                ST_PAUSED: begin
                    if (start && !pause) state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else if (count_q == 16'h0000) begin
                        state_n = ST_DONE;
                    end else if (en) begin
                        if (count_q == 16'h0001) begin
                            done_n = 1'b1;
                            if ((AUTO_RELOAD != 0) && (reload_q != 16'h0000)) begin
                                count_n = reload_q;
                            end else begin
                                count_n = 16'h0000;
                                state_n = ST_DONE;
                            end
                        end else begin
                            count_n  = dec_val;
                            sec_bo_n = bo1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;
    assign sec_bo  = sec_bo_q;

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: two instances (59:59 one-shot, 99:59 auto-reload)
// checked every cycle against a seconds-based reference model.
module tb_countdown_mmss;

    logic        clk;
    logic        rst, en, load, start, pause;
    logic [15:0] load_val;

    logic [15:0] count0, count1;
    logic [1:0]  state0, state1;
    logic        running0, running1, done0, done1, sec_bo0, sec_bo1;

    int compared   = 0;
    int mismatched = 0;

    countdown_mmss #(.MIN_TENS_MAX(5), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .start(start), .pause(pause),
        .load_val(load_val), .count(count0), .state(state0), .running(running0),
        .done(done0), .sec_bo(sec_bo0)
    );

    countdown_mmss #(.MIN_TENS_MAX(9), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .start(start), .pause(pause),
        .load_val(load_val), .count(count1), .state(state1), .running(running1),
        .done(done1), .sec_bo(sec_bo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: value kept as total seconds; state 0 idle, 1 run, 2 paused, 3 done.
    int m_secs [2];
    int m_rel  [2];
    int m_st   [2];
    int m_done [2];
    int m_bo   [2];
    int m_tmax [2] = '{5, 9};
    int m_auto [2] = '{0, 1};

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int clamp_secs(input logic [15:0] v, input int tmax);
        int mt, mo, st, so;
        mt = min_i(int'(v[15:12]), tmax);
        mo = min_i(int'(v[11:8]), 9);
        st = min_i(int'(v[7:4]), 5);
        so = min_i(int'(v[3:0]), 9);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step(input int i);
        m_done[i] = 0;
        m_bo[i]   = 0;
        if (rst) begin
            m_secs[i] = 0; m_rel[i] = 0; m_st[i] = 0;
        end else if (load && m_st[i] != 1) begin
            m_secs[i] = clamp_secs(load_val, m_tmax[i]);
            m_rel[i]  = m_secs[i];
            m_st[i]   = 0;
        end else if (m_st[i] == 0) begin
            if (start && m_secs[i] != 0) m_st[i] = 1;
        end else if (m_st[i] == 2) begin
            if (start && !pause) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            if (pause) m_st[i] = 2;
            else if (en) begin
                if (m_secs[i] == 1) begin
                    m_done[i] = 1;
                    if (m_auto[i] != 0 && m_rel[i] != 0) m_secs[i] = m_rel[i];
                    else begin m_secs[i] = 0; m_st[i] = 3; end
                end else begin
                    m_bo[i]   = (m_secs[i] % 60 == 0) ? 1 : 0;
                    m_secs[i] = m_secs[i] - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int i);
        logic [15:0] c;
        logic [1:0]  s;
        logic        r, d, b;
        c = (i == 0) ? count0   : count1;
        s = (i == 0) ? state0   : state1;
        r = (i == 0) ? running0 : running1;
        d = (i == 0) ? done0    : done1;
        b = (i == 0) ? sec_bo0  : sec_bo1;
        chk($sformatf("u%0d_count", i),   c, to_bcd(m_secs[i]));
        chk($sformatf("u%0d_state", i),   16'(s), 16'(m_st[i]));
        chk($sformatf("u%0d_running", i), 16'(r), (m_st[i] == 1) ? 16'd1 : 16'd0);
        chk($sformatf("u%0d_done", i),    16'(d), 16'(m_done[i]));
        chk($sformatf("u%0d_sec_bo", i),  16'(b), 16'(m_bo[i]));
    endtask

    // One clock: model advances with the inputs sampled at the edge, outputs checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_inst(0);
        check_inst(1);
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1; cycle(); rst = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        idle_inputs(); load = 1; load_val = v; cycle(); load = 0;
    endtask

    task automatic do_start();
        idle_inputs(); start = 1; cycle(); start = 0;
    endtask

    task automatic tick();
        idle_inputs(); en = 1; cycle(); en = 0;
    endtask

    int ndone;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = 0; m_rel[i] = 0; m_st[i] = 0; m_done[i] = 0; m_bo[i] = 0;
        end
        idle_inputs();
        load_val = 16'h0000;

        // Reset with en/start high
        rst = 1; en = 1; start = 1;
        cycle(); cycle();
        idle_inputs();
        chk("t1_count", count0, 16'h0000);
        chk("t1_state", 16'(state0), 16'h0000);
        chk("t1_done", 16'(done0), 16'h0000);

        // 01:02 runs down through the seconds borrow to expiry
        do_load(16'h0102);
        chk("t2_load", count0, 16'h0102);
        do_start();
        chk("t2_running", 16'(running0), 16'h0001);
        ndone = 0;
        for (int t = 1; t <= 62; t++) begin
            tick();
            if (done0) ndone++;
            if (t == 2) chk("t2_0100", count0, 16'h0100);
            if (t == 3) begin
                chk("t2_0059", count0, 16'h0059);
                chk("t2_sec_bo", 16'(sec_bo0), 16'h0001);
            end
            if (t == 62) begin
                chk("t2_zero", count0, 16'h0000);
                chk("t2_done_state", 16'(state0), 16'h0003);
                chk("t2_u1_reloaded", count1, 16'h0102);
            end
        end
        chk("t2_done_count", 16'(ndone), 16'h0001);
        tick();
        chk("t2_hold", count0, 16'h0000);

        // Pause holds the count against ticks
        do_reset();
        do_load(16'h0010);
        do_start();
        tick(); tick(); tick();
        chk("t3_0007", count0, 16'h0007);
        idle_inputs(); pause = 1; en = 1; start = 1; cycle();
        for (int t = 0; t < 5; t++) tick();
        chk("t3_paused_count", count0, 16'h0007);
        chk("t3_paused_state", 16'(state0), 16'h0002);
        idle_inputs(); start = 1; pause = 1; cycle();
        chk("t3_pair_paused", 16'(state0), 16'h0002);
        do_start();
        tick();
        chk("t3_0006", count0, 16'h0006);

        // Digit clamping, then start on zero is ignored
        do_reset();
        do_load(16'hFA7C);
        chk("t4_clamp_59", count0, 16'h5959);
        chk("t4_clamp_99", count1, 16'h9959);
        do_reset();
        do_start();
        chk("t4_zero_start", 16'(state0), 16'h0000);

        // Reset wins over everything mid-run
        do_load(16'h0005);
        do_start();
        tick();
        chk("t5_0004", count0, 16'h0004);
        rst = 1; en = 1; start = 1; load = 1; load_val = 16'h1234;
        cycle();
        idle_inputs();
        chk("t5_count", count0, 16'h0000);
        chk("t5_state", 16'(state0), 16'h0000);
        chk("t5_done", 16'(done0), 16'h0000);

        // Auto-reload keeps running
        do_reset();
        do_load(16'h0002);
        do_start();
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk("t6_state", 16'(state1), 16'h0001);
            if (t == 2 || t == 4) begin
                chk("t6_done", 16'(done1), 16'h0001);
                chk("t6_reload", count1, 16'h0002);
            end
        end

        // Randomized traffic, mostly small loads so expiry is reached often
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 1) == 1);
            load  = ($urandom_range(0, 29) == 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) load_val = 16'($urandom);
            else load_val = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
